// File: rtl/vend_ctrl_param.sv
// vend_ctrl_param
//   Parametrised vending-machine controller. Counts credit in nickel units
//   (nickel = 1, dime = 2, quarter = 5), holds a programmable price and a
//   stock counter per item, vends on select, and returns change as
//   dime/nickel pulses.
//
// Ports
//   clock, reset            : rising-edge clock, synchronous active-high reset
//   item_number             : item index for select, price write and restock
//   select                  : purchase request (level, sampled each cycle)
//   nickel_in/dime_in/quarter_in : coin-accepted strobes
//   cancel                  : refund all credit as change
//   price_wr_en/price_wr_data : write price of item_number
//   restock_en              : reload stock of item_number with DEFAULT_STOCK
//   dispense, dispensed_item: one-cycle vend pulse and the item vended
//   nickel_out, dime_out    : change-return pulses, one coin per cycle
//   credit                  : current credit
//   sold_out, insufficient, invalid_sel, coin_reject : one-cycle status pulses
//   busy                    : controller is vending or returning change

module vend_ctrl_param #(
    parameter int NUM_ITEMS     = 16,
    parameter int CREDIT_W      = 8,
    parameter int PRICE_W       = 8,
    parameter int STOCK_W       = 4,
    parameter int DEFAULT_PRICE = 3,
    parameter int DEFAULT_STOCK = 2,
    localparam int ITEM_W       = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [ITEM_W-1:0]   item_number,
    input  logic                select,
    input  logic                nickel_in,
    input  logic                dime_in,
    input  logic                quarter_in,
    input  logic                cancel,
    input  logic                price_wr_en,
    input  logic [PRICE_W-1:0]  price_wr_data,
    input  logic                restock_en,
    output logic                dispense,
    output logic [ITEM_W-1:0]   dispensed_item,
    output logic                nickel_out,
    output logic                dime_out,
    output logic [CREDIT_W-1:0] credit,
    output logic                sold_out,
    output logic                insufficient,
    output logic                invalid_sel,
    output logic                coin_reject,
    output logic                busy
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] VEND   = 2'd1;
    localparam logic [1:0] CHANGE = 2'd2;

    localparam logic [CREDIT_W:0] CREDIT_MAX_EXT = {1'b0, {CREDIT_W{1'b1}}};
    localparam logic [ITEM_W:0]   NUM_ITEMS_EXT  = (ITEM_W + 1)'(NUM_ITEMS);

    logic [1:0]          state;
    logic [PRICE_W-1:0]  price_q [NUM_ITEMS];
    logic [STOCK_W-1:0]  stock_q [NUM_ITEMS];

    // Next-state / next-output values
    logic [1:0]          state_d;
    logic [CREDIT_W-1:0] credit_d;
    logic [ITEM_W-1:0]   item_d;
    logic                dispense_d, nickel_d, dime_d;
    logic                sold_d, insuf_d, inval_d, reject_d;
    logic                price_we, restock_we, stock_dec;

    // Request decode
    logic                item_valid;
    logic [ITEM_W-1:0]   item_idx;
    logic [PRICE_W-1:0]  price_sel;
    logic [STOCK_W-1:0]  stock_sel;
    logic                coins_any;
    logic [3:0]          coin_sum;
    logic [CREDIT_W:0]   credit_sum;

    // One change-return step, shared by cancel, VEND exit and CHANGE
    logic                chg_active, chg_dime, chg_nickel;
    logic [CREDIT_W-1:0] chg_credit;

    assign item_valid = ({1'b0, item_number} < NUM_ITEMS_EXT);
    // Out-of-range indices are redirected to entry 0; their result is masked
    // by item_valid so the array is never read or written out of bounds.
    assign item_idx   = item_valid ? item_number : '0;
    assign price_sel  = price_q[item_idx];
    assign stock_sel  = stock_q[item_idx];

    assign coins_any  = nickel_in | dime_in | quarter_in;
    assign coin_sum   = {3'b000, nickel_in} + {2'b00, dime_in, 1'b0}
                      + (quarter_in ? 4'd5 : 4'd0);
    assign credit_sum = {1'b0, credit} + (CREDIT_W + 1)'(coin_sum);

    assign chg_active = (credit != '0);
    assign chg_dime   = (credit >= CREDIT_W'(2));
    assign chg_nickel = (credit == CREDIT_W'(1));
    assign chg_credit = chg_dime ? credit - CREDIT_W'(2) : '0;

    always_comb begin
        state_d    = state;
        credit_d   = credit;
        item_d     = dispensed_item;
        dispense_d = 1'b0;
        nickel_d   = 1'b0;
        dime_d     = 1'b0;
        sold_d     = 1'b0;
        insuf_d    = 1'b0;
        inval_d    = 1'b0;
        reject_d   = 1'b0;
        price_we   = 1'b0;
        restock_we = 1'b0;
        stock_dec  = 1'b0;

        case (state)
            IDLE: begin
                if (cancel) begin
                    // Cancel claims the cycle; the first change coin is issued
                    // on the same edge that leaves IDLE.
                    reject_d = coins_any;
                    if (chg_active) begin
                        dime_d   = chg_dime;
                        nickel_d = chg_nickel;
                        credit_d = chg_credit;
                        state_d  = CHANGE;
                    end
                end else if (price_wr_en || restock_en) begin
                    reject_d   = coins_any;
                    price_we   = price_wr_en && item_valid;
                    restock_we = restock_en && item_valid;
                end else if (select) begin
                    reject_d = coins_any;
                    if (!item_valid) begin
                        inval_d = 1'b1;
                    end else if (stock_sel == '0) begin
                        sold_d = 1'b1;
                    end else if (credit < CREDIT_W'(price_sel)) begin
                        insuf_d = 1'b1;
                    end else begin
                        credit_d   = credit - CREDIT_W'(price_sel);
                        stock_dec  = 1'b1;
                        item_d     = item_number;
                        dispense_d = 1'b1;
                        state_d    = VEND;
                    end
                end else if (coins_any) begin
                    if (credit_sum > CREDIT_MAX_EXT) begin
                        reject_d = 1'b1;
                    end else begin
                        credit_d = credit_sum[CREDIT_W-1:0];
                    end
                end
            end

            VEND, CHANGE: begin
                // Leaving VEND issues the first change coin directly so the
                // pulse train starts the cycle after dispense; the last coin's
                // cycle is still spent in CHANGE, returning to IDLE after it.
                reject_d = coins_any;
                if (chg_active) begin
                    dime_d   = chg_dime;
                    nickel_d = chg_nickel;
                    credit_d = chg_credit;
                    state_d  = CHANGE;
                end else begin
                    state_d  = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            credit         <= '0;
            dispensed_item <= '0;
            dispense       <= 1'b0;
            nickel_out     <= 1'b0;
            dime_out       <= 1'b0;
            sold_out       <= 1'b0;
            insufficient   <= 1'b0;
            invalid_sel    <= 1'b0;
            coin_reject    <= 1'b0;
            busy           <= 1'b0;
            for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
                price_q[i] <= PRICE_W'(DEFAULT_PRICE);
                stock_q[i] <= STOCK_W'(DEFAULT_STOCK);
            end
        end else begin
            state          <= state_d;
            credit         <= credit_d;
            dispensed_item <= item_d;
            dispense       <= dispense_d;
            nickel_out     <= nickel_d;
            dime_out       <= dime_d;
            sold_out       <= sold_d;
            insufficient   <= insuf_d;
            invalid_sel    <= inval_d;
            coin_reject    <= reject_d;
            busy           <= (state_d != IDLE);
            if (price_we) begin
                price_q[item_idx] <= price_wr_data;
            end
            if (restock_we) begin
                stock_q[item_idx] <= STOCK_W'(DEFAULT_STOCK);
            end else if (stock_dec) begin
                stock_q[item_idx] <= stock_sel - STOCK_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_vend_ctrl_param.sv
// tb_vend_ctrl_param
//   Self-checking bench for vend_ctrl_param (NUM_ITEMS = 12 so that an
//   out-of-range item index is representable). Each cycle's expected outputs
//   are pushed to a scoreboard queue when the stimulus is driven and popped
//   and compared one clock later.

module tb_vend_ctrl_param;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] item_number;
    logic       select, nickel_in, dime_in, quarter_in, cancel;
    logic       price_wr_en, restock_en;
    logic [7:0] price_wr_data;
    logic       dispense, nickel_out, dime_out;
    logic [3:0] dispensed_item;
    logic [7:0] credit;
    logic       sold_out, insufficient, invalid_sel, coin_reject, busy;

    localparam logic [2:0] S_NONE  = 3'b000;
    localparam logic [2:0] S_SOLD  = 3'b100;
    localparam logic [2:0] S_INSUF = 3'b010;
    localparam logic [2:0] S_INVAL = 3'b001;

    typedef struct packed {
        logic [7:0] credit;
        logic       disp;
        logic [3:0] item;
        logic       nk;
        logic       dm;
        logic [2:0] stat;
        logic       rej;
        logic       bsy;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] last_item;
    int         n_checks = 0;
    int         n_pass   = 0;

    vend_ctrl_param #(
        .NUM_ITEMS     (12),
        .CREDIT_W      (8),
        .PRICE_W       (8),
        .STOCK_W       (4),
        .DEFAULT_PRICE (3),
        .DEFAULT_STOCK (2)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .item_number    (item_number),
        .select         (select),
        .nickel_in      (nickel_in),
        .dime_in        (dime_in),
        .quarter_in     (quarter_in),
        .cancel         (cancel),
        .price_wr_en    (price_wr_en),
        .price_wr_data  (price_wr_data),
        .restock_en     (restock_en),
        .dispense       (dispense),
        .dispensed_item (dispensed_item),
        .nickel_out     (nickel_out),
        .dime_out       (dime_out),
        .credit         (credit),
        .sold_out       (sold_out),
        .insufficient   (insufficient),
        .invalid_sel    (invalid_sel),
        .coin_reject    (coin_reject),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int got, input int want);
        n_checks++;
        if (got == want) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, got, want);
        end
    endtask

    task automatic clear_inputs();
        reset         = 1'b0;
        item_number   = '0;
        select        = 1'b0;
        nickel_in     = 1'b0;
        dime_in       = 1'b0;
        quarter_in    = 1'b0;
        cancel        = 1'b0;
        price_wr_en   = 1'b0;
        price_wr_data = '0;
        restock_en    = 1'b0;
    endtask

    // Push the outputs expected after the next edge, clock, then pop and
    // compare against the DUT. dispensed_item follows the last expected vend.
    task automatic tick(input string tag, input int c, input bit disp,
                        input bit nk, input bit dm, input logic [2:0] st,
                        input bit rej, input bit bsy);
        exp_t e;
        exp_t w;
        if (reset)     last_item = '0;
        else if (disp) last_item = item_number;
        e.credit = c[7:0];
        e.disp   = disp;
        e.item   = last_item;
        e.nk     = nk;
        e.dm     = dm;
        e.stat   = st;
        e.rej    = rej;
        e.bsy    = bsy;
        sb.push_back(e);
        @(posedge clock);
        #1;
        if (sb.size() == 0) begin
            check({tag, ".sb_empty"}, 1, 0);
        end else begin
            w = sb.pop_front();
            check({tag, ".credit"},   int'(credit),         int'(w.credit));
            check({tag, ".dispense"}, int'(dispense),       int'(w.disp));
            check({tag, ".item"},     int'(dispensed_item), int'(w.item));
            check({tag, ".nickel"},   int'(nickel_out),     int'(w.nk));
            check({tag, ".dime"},     int'(dime_out),       int'(w.dm));
            check({tag, ".sold"},     int'(sold_out),       int'(w.stat[2]));
            check({tag, ".insuf"},    int'(insufficient),   int'(w.stat[1]));
            check({tag, ".inval"},    int'(invalid_sel),    int'(w.stat[0]));
            check({tag, ".reject"},   int'(coin_reject),    int'(w.rej));
            check({tag, ".busy"},     int'(busy),           int'(w.bsy));
        end
        clear_inputs();
    endtask

    initial begin
        last_item = '0;
        clear_inputs();
        #2;

        // Reset state
        reset = 1'b1; tick("rst0", 0, 0, 0, 0, S_NONE, 0, 0);
        reset = 1'b1; tick("rst1", 0, 0, 0, 0, S_NONE, 0, 0);

        // Exact credit: dime + nickel, buy item 5, no change
        dime_in = 1'b1;   tick("t1_dime", 2, 0, 0, 0, S_NONE, 0, 0);
        nickel_in = 1'b1; tick("t1_nick", 3, 0, 0, 0, S_NONE, 0, 0);
        select = 1'b1; item_number = 4'd5;
        tick("t1_sel", 0, 1, 0, 0, S_NONE, 0, 1);
        tick("t1_vend", 0, 0, 0, 0, S_NONE, 0, 0);

        // Quarter, buy item 0, one dime change
        quarter_in = 1'b1; tick("t2_q", 5, 0, 0, 0, S_NONE, 0, 0);
        select = 1'b1; item_number = 4'd0;
        tick("t2_sel", 2, 1, 0, 0, S_NONE, 0, 1);
        tick("t2_chg", 0, 0, 0, 1, S_NONE, 0, 1);
        tick("t2_idle", 0, 0, 0, 0, S_NONE, 0, 0);

        // Exhaust item 2, sold out, restock, buy again
        for (int k = 0; k < 2; k++) begin
            nickel_in = 1'b1; dime_in = 1'b1;
            tick("t3_coin", 3, 0, 0, 0, S_NONE, 0, 0);
            select = 1'b1; item_number = 4'd2;
            tick("t3_buy", 0, 1, 0, 0, S_NONE, 0, 1);
            tick("t3_idle", 0, 0, 0, 0, S_NONE, 0, 0);
        end
        nickel_in = 1'b1; dime_in = 1'b1;
        tick("t3_coin2", 3, 0, 0, 0, S_NONE, 0, 0);
        select = 1'b1; item_number = 4'd2;
        tick("t3_sold", 3, 0, 0, 0, S_SOLD, 0, 0);
        restock_en = 1'b1; item_number = 4'd2;
        tick("t3_restock", 3, 0, 0, 0, S_NONE, 0, 0);
        select = 1'b1; item_number = 4'd2;
        tick("t3_rebuy", 0, 1, 0, 0, S_NONE, 0, 1);
        tick("t3_idle2", 0, 0, 0, 0, S_NONE, 0, 0);

        // Insufficient, cancel refund, coin rejected alongside select
        dime_in = 1'b1; tick("t4_dime", 2, 0, 0, 0, S_NONE, 0, 0);
        select = 1'b1; item_number = 4'd1;
        tick("t4_insuf", 2, 0, 0, 0, S_INSUF, 0, 0);
        cancel = 1'b1; tick("t4_cancel", 0, 0, 0, 1, S_NONE, 0, 1);
        tick("t4_idle", 0, 0, 0, 0, S_NONE, 0, 0);
        nickel_in = 1'b1; dime_in = 1'b1;
        tick("t4_coin", 3, 0, 0, 0, S_NONE, 0, 0);
        select = 1'b1; item_number = 4'd1; dime_in = 1'b1;
        tick("t4_selcoin", 0, 1, 0, 0, S_NONE, 1, 1);
        tick("t4_idle2", 0, 0, 0, 0, S_NONE, 0, 0);

        // Saturation at CREDIT_MAX, invalid item, long change train
        for (int k = 1; k <= 50; k++) begin
            quarter_in = 1'b1;
            tick("t5_fill", 5 * k, 0, 0, 0, S_NONE, 0, 0);
        end
        nickel_in = 1'b1; dime_in = 1'b1;
        tick("t5_253", 253, 0, 0, 0, S_NONE, 0, 0);
        quarter_in = 1'b1; tick("t5_sat", 253, 0, 0, 0, S_NONE, 1, 0);
        nickel_in = 1'b1;  tick("t5_254", 254, 0, 0, 0, S_NONE, 0, 0);
        select = 1'b1; item_number = 4'd15;
        tick("t5_inval", 254, 0, 0, 0, S_INVAL, 0, 0);
        select = 1'b1; item_number = 4'd3;
        tick("t5_sel", 251, 1, 0, 0, S_NONE, 0, 1);
        for (int k = 1; k <= 125; k++) begin
            if (k == 10) nickel_in = 1'b1;
            tick("t5_dime", 251 - 2 * k, 0, 0, 1, S_NONE, k == 10, 1);
        end
        tick("t5_nick", 0, 0, 1, 0, S_NONE, 0, 1);
        tick("t5_idle", 0, 0, 0, 0, S_NONE, 0, 0);

        // Price write, change of two dimes, reset in the second dime cycle
        price_wr_en = 1'b1; item_number = 4'd7; price_wr_data = 8'd1;
        tick("t6_pw", 0, 0, 0, 0, S_NONE, 0, 0);
        quarter_in = 1'b1; tick("t6_q", 5, 0, 0, 0, S_NONE, 0, 0);
        select = 1'b1; item_number = 4'd7;
        tick("t6_sel", 4, 1, 0, 0, S_NONE, 0, 1);
        tick("t6_dime1", 2, 0, 0, 1, S_NONE, 0, 1);
        tick("t6_dime2", 0, 0, 0, 1, S_NONE, 0, 1);
        reset = 1'b1; tick("t6_rst", 0, 0, 0, 0, S_NONE, 0, 0);
        tick("t6_after", 0, 0, 0, 0, S_NONE, 0, 0);

        // Reset restored item 7's price to 3: one nickel is not enough
        nickel_in = 1'b1; tick("t7_nick", 1, 0, 0, 0, S_NONE, 0, 0);
        select = 1'b1; item_number = 4'd7;
        tick("t7_insuf", 1, 0, 0, 0, S_INSUF, 0, 0);
        cancel = 1'b1; tick("t7_cancel", 0, 0, 1, 0, S_NONE, 0, 1);
        tick("t7_idle", 0, 0, 0, 0, S_NONE, 0, 0);

        // Reset with change still owed forfeits the remainder
        quarter_in = 1'b1; tick("t8_q1", 5, 0, 0, 0, S_NONE, 0, 0);
        quarter_in = 1'b1; tick("t8_q2", 10, 0, 0, 0, S_NONE, 0, 0);
        select = 1'b1; item_number = 4'd0;
        tick("t8_sel", 7, 1, 0, 0, S_NONE, 0, 1);
        tick("t8_dime", 5, 0, 0, 1, S_NONE, 0, 1);
        reset = 1'b1; tick("t8_rst", 0, 0, 0, 0, S_NONE, 0, 0);
        tick("t8_quiet1", 0, 0, 0, 0, S_NONE, 0, 0);
        tick("t8_quiet2", 0, 0, 0, 0, S_NONE, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
